// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop line synchroniser and mid-bit sampling.
// Latency: the byte is presented one clk after the stop-bit sample, which is
//          1+HALF+9*CLKS_PER_BIT clks after the start bit is first seen on rx_s.
// Backpressure: none; o_rx_valid and o_frame_err are one-cycle pulses that the consumer must take.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   i_rx         asynchronous serial line, idles high
//   o_rx_d       last correctly framed byte; holds until the next good frame
//   o_rx_valid   one-cycle strobe; o_rx_d is new in the same cycle
//   o_frame_err  one-cycle strobe; the stop bit was sampled low
//   o_busy       high while a frame is being received or a break is being waited out
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_d,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state_q;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      sh_q;
  logic [7:0]      rx_d_q;
  logic            rx_valid_q;
  logic            frame_err_q;
  logic            busy_q;
  logic            rx_s;

  // Synchroniser resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_rx};
    end
  end

  assign rx_s = sync_q[1];

  // o_busy is registered alongside each state change so that it always
  // reflects the state register in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      rx_d_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_C) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST_C) begin
            cnt_q <= '0;
            sh_q  <= {rx_s, sh_q[7:1]};
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == LAST_C) begin
            cnt_q <= '0;
            if (rx_s) begin
              rx_d_q     <= sh_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be mistaken for a new start bit.
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_rx_d      = rx_d_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clks per bit.
// Latency: expected pulse timing is computed from the driven falling edge.
// Backpressure: not applicable; the bench only drives the serial line.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_d;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor: records every pulse; only this block writes these.
  logic [7:0] vd[$];
  int         vt[$];
  int         fe_n = 0;
  int         bad_pulse = 0;
  logic       prev_pulse = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (rx),
    .o_rx_d     (rx_d),
    .o_rx_valid (rx_valid),
    .o_frame_err(frame_err),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vd.push_back(rx_d);
      vt.push_back(cyc);
    end
    if (frame_err) fe_n++;
    if ((rx_valid && frame_err) || (prev_pulse && (rx_valid || frame_err))) bad_pulse++;
    prev_pulse = rx_valid || frame_err;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; t_fall is the posedge count when the start bit is driven.
  task automatic send(input logic [7:0] b, input int per, input logic stop, output int t_fall);
    rx = 1'b0;
    t_fall = cyc;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop;
    repeat (per) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_d !== 8'h00) begin errors++; $display("FAIL reset_rx_d: got %h want 00", rx_d); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_single;
    int n0, f0, tf;
    n0 = vd.size(); f0 = fe_n;
    send(8'hA5, CPB, 1'b1, tf);
    idle(10);
    checks++; if (vd.size() - n0 !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", vd.size() - n0); end
    if (vd.size() > n0) begin
      checks++; if (vd[n0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", vd[n0]); end
      // 3 clks to T0 (2 sync + IDLE decision), then 1+8+9*16 to the stop sample.
      checks++; if (vt[n0] - tf < 155 || vt[n0] - tf > 157) begin
        errors++; $display("FAIL single_latency: got %0d want 156", vt[n0] - tf);
      end
    end
    checks++; if (fe_n - f0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d want 0", fe_n - f0); end
  endtask

  task automatic test_glitch;
    int n0, f0, busy_cnt;
    n0 = vd.size(); f0 = fe_n; busy_cnt = 0;
    rx = 1'b0;
    repeat (5) begin @(negedge clk); if (busy) busy_cnt++; end
    rx = 1'b1;
    repeat (40) begin @(negedge clk); if (busy) busy_cnt++; end
    checks++; if (vd.size() - n0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", vd.size() - n0); end
    checks++; if (fe_n - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d want 0", fe_n - f0); end
    checks++; if (busy_cnt < 1 || busy_cnt > 10) begin errors++; $display("FAIL glitch_busy_len: got %0d want 1..10", busy_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_frame_err;
    int n0, f0, tf;
    n0 = vd.size(); f0 = fe_n;
    send(8'h3C, CPB, 1'b0, tf);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (fe_n - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fe_n - f0); end
    checks++; if (vd.size() - n0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", vd.size() - n0); end
    checks++; if (rx_d !== 8'hA5) begin errors++; $display("FAIL ferr_hold: got %h want a5", rx_d); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b want 1", busy); end
    idle(2 * CPB);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_release: got %b want 0", busy); end
    send(8'h81, CPB, 1'b1, tf);
    idle(20);
    checks++; if (vd.size() - n0 !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", vd.size() - n0); end
    if (vd.size() > n0) begin
      checks++; if (vd[n0] !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h want 81", vd[n0]); end
    end
    checks++; if (fe_n - f0 !== 1) begin errors++; $display("FAIL ferr_total: got %0d want 1", fe_n - f0); end
  endtask

  task automatic test_back_to_back;
    int n0, tf;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h55;
    n0 = vd.size();
    for (int i = 0; i < 3; i++) send(exp_d[i], CPB, 1'b1, tf);
    idle(20);
    checks++; if (vd.size() - n0 !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", vd.size() - n0); end
    if (vd.size() - n0 == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (vd[n0+i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, vd[n0+i], exp_d[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++; if (vt[n0+i] - vt[n0+i-1] !== 10 * CPB) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, vt[n0+i] - vt[n0+i-1], 10 * CPB);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n0, f0, tf;
    logic [7:0] b;
    b = 8'hF0;
    n0 = vd.size(); f0 = fe_n;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 4) begin
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (rx_d !== 8'h00) begin errors++; $display("FAIL rstmid_rx_d: got %h want 00", rx_d); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
          errors++; $display("FAIL rstmid_pulses: got %b%b want 00", rx_valid, frame_err);
        end
        repeat (CPB - CPB / 2 - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    idle(CPB);
    checks++; if (vd.size() - n0 !== 0 || fe_n - f0 !== 0) begin
      errors++; $display("FAIL rstmid_aborted: got %0d valid %0d ferr want 0 0", vd.size() - n0, fe_n - f0);
    end
    send(8'h0F, CPB, 1'b1, tf);
    idle(20);
    checks++; if (vd.size() - n0 !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d want 1", vd.size() - n0); end
    if (vd.size() > n0) begin
      checks++; if (vd[n0] !== 8'h0F) begin errors++; $display("FAIL rstmid_next_data: got %h want 0f", vd[n0]); end
    end
  endtask

  task automatic test_skew;
    int n0, f0, tf;
    n0 = vd.size(); f0 = fe_n;
    send(8'h69, CPB + 1, 1'b1, tf);
    idle(20);
    checks++; if (vd.size() - n0 !== 1) begin errors++; $display("FAIL skew_count: got %0d want 1", vd.size() - n0); end
    if (vd.size() > n0) begin
      checks++; if (vd[n0] !== 8'h69) begin errors++; $display("FAIL skew_data: got %h want 69", vd[n0]); end
    end
    checks++; if (fe_n - f0 !== 0) begin errors++; $display("FAIL skew_frame_err: got %0d want 0", fe_n - f0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_skew();
    checks++; if (bad_pulse !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d bad pulses want 0", bad_pulse); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the 8N1 serial link at 115200 baud, the receiving end of our UART Tx path. It synchronises the asynchronous line, detects and validates the start bit, and samples 8 data bits LSB-first plus one stop bit at mid-bit. It delivers each byte on a one-cycle valid strobe and flags framing errors. It sits between the board RX pin and the byte-consuming logic, with no flow control.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per bit (50 MHz / 115200). Legal range ≥ 4. HALF = CLKS_PER_BIT/2 (integer division).
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- i_rx  input  1  asynchronous serial line; idles high.
- o_rx_d  output  8  last correctly framed byte; holds until the next good frame.
- o_rx_valid  output  1  one-cycle pulse; o_rx_d is new in the same cycle.
- o_frame_err  output  1  one-cycle pulse; stop bit sampled 0.
- o_busy  output  1  high whenever state ≠ IDLE.

## Operation
- Line format: idle 1, start bit 0, d[0]..d[7] LSB-first, stop bit 1.
- Synchroniser:
  - i_rx passes through 2 flip-flops, both reset to 1. rx_s is the second stage.
  - All decisions use rx_s only.
- Counters: bit-timer cnt, width clog2(CLKS_PER_BIT); bit index idx, 3 bits; shift register sh[7:0], filled by shifting right with the new bit into sh[7].
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: cnt=0. rx_s==0 → START.
  - START: cnt increments each cycle. At cnt==HALF: rx_s==0 → DATA with cnt=0, idx=0; rx_s==1 → IDLE (glitch rejected, no output).
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into sh and clear cnt. idx==7 at the sample → STOP; otherwise idx+1.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1 → o_rx_d<=sh, pulse o_rx_valid, → IDLE.
    - 0 → pulse o_frame_err, o_rx_d unchanged, → WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then → IDLE. This keeps a break condition from retriggering a frame.
- o_rx_valid and o_frame_err are mutually exclusive and never high for two consecutive cycles.
- Reset mid-operation:
  - State → IDLE.
  - cnt, idx and sh clear to 0.
  - All outputs take their reset values on the next edge.
  - The partial frame is discarded, with no pulses.

## Timing
- Reset values: o_rx_d=8'h00, o_rx_valid=0, o_frame_err=0, o_busy=0; synchroniser=2'b11.
- Let T0 be the edge at which IDLE sees rx_s==0. At T0+1 the FSM is in START and o_busy is 1. T0 itself is 2–3 clks after the i_rx falling edge.
- Start check at T0+1+HALF.
- Data bit k is sampled at T0+1+HALF+(k+1)·CLKS_PER_BIT, for k=0..7.
- Stop bit sampled at T0+1+HALF+9·CLKS_PER_BIT.
- o_rx_valid or o_frame_err is high in the cycle after the stop sample. In that same cycle the FSM is already in IDLE (or WAIT_HIGH), so o_busy is 0 on a good frame.
- Back-to-back frames with zero idle between stop and the next start: IDLE is re-entered about HALF clks before the next falling edge, so there is no loss.
- Tolerated baud mismatch: ±(HALF−1)/(10·CLKS_PER_BIT) cumulative over a frame.

## Test plan
(All scenarios use CLKS_PER_BIT=16, HALF=8, 16 clks per bit.)
- Single frame 0xA5 with ideal timing → exactly one o_rx_valid pulse, o_rx_d=8'hA5, and it arrives 1+8+9·16+1 clks after T0 (±2 sync clks). o_frame_err stays 0.
- i_rx low glitch of 5 clks in idle → FSM returns to IDLE at the start check. No valid, no frame_err. o_busy high for ≤10 clks.
- Frame 0x3C with stop bit forced 0, line held low 40 clks, then frame 0x81 → one o_frame_err pulse and o_rx_d stays at its previous value. Nothing is reported while low, then o_rx_d=8'h81 with valid.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three valid pulses, 160 clks apart, with data 00, FF, 55 in order.
- rst_n low for 1 clk during bit 4 of frame 0xF0, then a clean frame 0x0F → no pulse for the aborted frame. All outputs are 0 after reset. Next result is o_rx_d=8'h0F.
- Baud skew: frame 0x69 sent with a 17-clk bit period → o_rx_d=8'h69 with valid and no frame_err.
